// File: rtl/mul16s_acc_stage.sv
// Signed product accumulator: sums 32-bit products into ACC_W-bit groups and holds each group result until it is consumed.
// Optional saturation is enabled by defining MUL16S_ACC_SAT_EN; without it the sum wraps and ovf_o reads 0.
module mul16s_acc_stage #(
  parameter int ACC_W     = 40,
  parameter int MAX_BEATS = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       prod_i,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_o,
  output logic [7:0]        cnt_o,
  output logic              trunc_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BEATS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             trunc_q, trunc_d;
  logic [ACC_W-1:0] prod_ext;
  logic [7:0]       cnt_next;
  logic             accept;
  logic             close;

`ifdef MUL16S_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign prod_ext  = {{(ACC_W-32){prod_i[31]}}, prod_i};
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  // The first beat of a group always counts as 1, regardless of the stale count.
  assign cnt_next  = (state_q == IDLE) ? 8'd1 : cnt_q + 8'd1;
  assign close     = in_last || (cnt_next == MAX_CNT);
  assign acc_o     = acc_q;
  assign cnt_o     = cnt_q;
  assign trunc_o   = trunc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
`ifdef MUL16S_ACC_SAT_EN
    ovf_d   = ovf_q;
    sum     = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          cnt_d   = cnt_next;
          trunc_d = !in_last && (cnt_next == MAX_CNT);
          state_d = close ? HOLD : ACCUM;
          if (state_q == IDLE) begin
            acc_d = prod_ext;
`ifdef MUL16S_ACC_SAT_EN
            ovf_d = 1'b0;
`endif
          end else begin
`ifdef MUL16S_ACC_SAT_EN
            // Top two sum bits disagree exactly when the result leaves the ACC_W range.
            if (sum[ACC_W] != sum[ACC_W-1]) begin
              acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum[ACC_W-1:0];
            end
`else
            acc_d = acc_q + prod_ext;
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
`ifdef MUL16S_ACC_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
`ifdef MUL16S_ACC_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: doc/mul16s_acc_stage.md
MUL16S_ACC_STAGE -- requirements
Module: mul16s_acc_stage

Interface
REQ-001 SHALL have parameter ACC_W, default 40: accumulator width in bits (legal range 33..64).
REQ-002 SHALL have parameter MAX_BEATS, default 255: maximum number of products per accumulation group (1..255).
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: prod_i and in_last are valid.
REQ-006 SHALL have port in_ready, output, 1: stage accepts a product this cycle.
REQ-007 SHALL have port prod_i, input, 32: signed 16x16 product from the upstream approximate multiplier.
REQ-008 SHALL have port in_last, input, 1: the current beat is the final product of its group.
REQ-009 SHALL have port out_valid, output, 1: group result is presented.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port acc_o, output, ACC_W: signed group sum.
REQ-012 SHALL have port cnt_o, output, 8: number of products in the group.
REQ-013 SHALL have port trunc_o, output, 1: group was closed by MAX_BEATS, not by in_last.
REQ-014 SHALL have port ovf_o, output, 1: the accumulator saturated during the group.

Function
REQ-015 SHALL implement the states IDLE, ACCUM and HOLD.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-017 A beat is accepted when in_valid and in_ready are both 1; input values SHALL be ignored otherwise.
REQ-018 Accept in IDLE: acc loads sign-extended prod_i, cnt loads 1, ovf clears, and state moves to ACCUM (or to HOLD if closing).
REQ-019 Accept in ACCUM: acc is updated to acc plus sign-extended prod_i, computed at ACC_W+1 bits, and cnt is incremented.
REQ-020 A group SHALL close on an accepted beat with in_last=1, or when the accepted beat makes cnt equal MAX_BEATS; the latter sets trunc_o=1.
REQ-021 On close, state SHALL move to HOLD on the next edge; out_valid, acc_o, cnt_o, trunc_o and ovf_o are valid one cycle after the closing beat (latency 1).
REQ-022 In HOLD, all outputs SHALL stay stable until out_valid and out_ready are both 1; state then moves to IDLE, and in_ready rises on the following cycle.
REQ-023 A single-beat group (in_last on the first beat) SHALL yield cnt_o=1 and acc_o=prod_i.
REQ-024 When in_last=1 coincides with cnt reaching MAX_BEATS, trunc_o SHALL be 0.
REQ-025 Stalls (in_valid=0 in ACCUM) SHALL hold all state indefinitely.

Reset
REQ-026 On reset: state goes to IDLE, acc goes to 0, cnt goes to 0, out_valid=0, trunc_o=0, ovf_o=0, and in_ready=1 on the first cycle after reset.
REQ-027 Reset mid-group or in HOLD SHALL discard the partial or pending result; no out_valid follows.

Configuration
REQ-028 Macro MUL16S_ACC_SAT_EN defined: when the ACC_W+1 sum exceeds the signed ACC_W range, acc clamps to the signed maximum or minimum, and ovf_o is set sticky for the group.
REQ-029 Macro MUL16S_ACC_SAT_EN undefined: the sum wraps modulo 2^ACC_W, and ovf_o is tied to 0.

Verification
REQ-030 Products 100, -40, 7 with in_last on the third beat -> one cycle later: out_valid=1, acc_o=67, cnt_o=3, trunc_o=0.
REQ-031 Single beat 0x8000_0000 with in_last -> acc_o=-2147483648 sign-extended, cnt_o=1.
REQ-032 MAX_BEATS=4, five beats of 1 with no in_last -> first result: acc_o=4, cnt_o=4, trunc_o=1; fifth beat waits because in_ready=0 during HOLD.
REQ-033 out_ready held 0 for 10 cycles in HOLD -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-034 ACC_W=33, repeated 0x7FFF_FFFF -> with MUL16S_ACC_SAT_EN: acc_o=2^32-1, ovf_o=1; without it: wrapped value, ovf_o=0.
REQ-035 reset asserted after 2 beats of a group -> next cycle: IDLE, in_ready=1; a new 1-beat group of 5 then yields acc_o=5.
